control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microstep controller for the 8-bit computer.
- Owns the T-state step counter, which counts up and wraps to 0 at a per-instruction step limit.
- Decodes the current opcode, step and flags into the 16-bit control word that drives the bus, registers, ALU and program counter.
- Sits between the instruction register and flags register on the input side and every datapath control input on the output side.

Parameters:
- STEP_W, 3, width of the step counter.
- MAX_STEPS, 5, longest instruction length in steps (T0..T4); the step counter never exceeds MAX_STEPS-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  step enable; 0 freezes the sequencer.
- ir_op  input  4  opcode, upper nibble of the instruction register.
- carry_flag  input  1  registered ALU carry.
- zero_flag  input  1  registered ALU zero.
- ctrl  output  16  control word, one-hot-per-signal (bit map below).
- step  output  STEP_W  current T-state.
- instr_done  output  1  high during the final step of the current instruction.
- halted  output  1  high once an HLT instruction has executed.

Behaviour:
- Reset:
  - Synchronous, active-high: one clock and one reset input.
  - While reset=1, ctrl=0 and instr_done=0.
  - After the reset edge: step=0, state=RUN, halted=0.
  - Reset mid-instruction abandons the instruction; the next cycle is fetch T0.
- ctrl bit map: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- ctrl, instr_done and halted are combinational from the registered state, step, ir_op and flags. There are no registered outputs besides step and halted.
- Fetch, common to all opcodes:
  - T0: CO|MI.
  - T1: RO|II|CE.
  - ir_op is valid from T2 onward.
- Execute steps; length is the step limit and the last step index is length-1:
  - 0000 NOP: length 2.
  - 0001 LDA: T2 IO|MI, T3 RO|AI; length 4.
  - 0010 ADD: T2 IO|MI, T3 RO|BI, T4 EO|AI|FI; length 5.
  - 0011 SUB: as ADD, with SU added at T4; length 5.
  - 0100 STA: T2 IO|MI, T3 AO|RI; length 4.
  - 0101 LDI: T2 IO|AI; length 3.
  - 0110 JMP: T2 IO|J; length 3.
  - 0111 JC: T2 IO|J if carry_flag=1, else 0; length 3 either way.
  - 1000 JZ: as JC, using zero_flag.
  - 1110 OUT: T2 AO|OI; length 3.
  - 1111 HLT: T2 HLT; length 3.
  - All other opcodes: treated as NOP (length 2, no execute step).
- Step counter:
  - With run=1 in RUN: step <= 0 if step == length-1, else step+1.
  - During T0/T1 the length is unknown; step always advances 0 to 1 to 2, except for NOP/undefined opcodes, which wrap at T1 using ir_op.
- instr_done: 1 exactly when run=1, state=RUN and step == length-1.
- run=0:
  - step and state hold; ctrl=0; instr_done=0.
  - Resuming with run=1 continues from the held step with no lost or repeated step.
- State machine RUN, HALT:
  - RUN to HALT on the rising edge that ends HLT T2 with run=1; step <= 0 on that edge.
  - HALT: ctrl=0, instr_done=0, halted=1, step=0. Only reset leaves HALT; run and ir_op are ignored.
- Flag sampling: flags are sampled combinationally in JC/JZ T2 only; flag changes at other steps have no effect.
- Step width: step never reaches MAX_STEPS. Values above MAX_STEPS-1 are unreachable; if ever forced, the next edge returns step to 0.

Test Plan:
- Reset, then run=1 with ir_op=0001 (LDA):
  - ctrl sequence 0x4004, 0x1408, 0x4800, 0x1200.
  - step 0,1,2,3,0.
  - instr_done high only in cycle 4.
- ir_op=0011 (SUB):
  - T4 ctrl = 0x02C1.
  - step wraps 4 to 0.
  - Two back-to-back SUBs give exactly 10 cycles.
- ir_op=0111 (JC):
  - carry_flag=0: T2 ctrl=0x0000.
  - carry_flag=1: T2 ctrl=0x0802.
  - Length is 3 in both cases.
- ir_op=1111 (HLT):
  - T2 ctrl=0x8000.
  - Thereafter halted=1, ctrl=0, step=0 for 20 cycles despite run=1 and opcode changes.
  - reset returns to T0 with ctrl=0x4004.
- run=0 held 3 cycles during ADD T3:
  - step stays 3, ctrl=0.
  - On resume, T3 ctrl=0x1020, then T4.
  - Total active cycles 5.
- Reset asserted at LDA T2; ir_op=1010 (undefined) afterwards:
  - After reset edge, step=0.
  - Instruction runs T0, T1 with instr_done in T1, then wraps to T0.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microstep controller for the 8-bit computer. It owns the T-state step
// counter and turns the current opcode, step and ALU flags into the 16-bit
// control word that drives the bus, registers, ALU and program counter.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   run         step enable; 0 freezes the sequencer and blanks ctrl
//   ir_op       opcode (upper nibble of the instruction register)
//   carry_flag  registered ALU carry, used only by JC at T2
//   zero_flag   registered ALU zero, used only by JZ at T2
//   ctrl        control word, bit map:
//               15 HLT 14 MI 13 RI 12 RO 11 IO 10 II 9 AI 8 AO
//                7 EO   6 SU  5 BI  4 OI  3 CE  2 CO 1 J  0 FI
//   step        current T-state
//   instr_done  high during the final step of the current instruction
//   halted      high once an HLT instruction has executed
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        ir_op,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              instr_done,
  output logic              halted
);

  // Control word bit positions
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [STEP_W-1:0] STEP_0     = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_1     = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_2     = STEP_W'(2);
  localparam logic [STEP_W-1:0] STEP_3     = STEP_W'(3);
  localparam logic [STEP_W-1:0] STEP_4     = STEP_W'(4);
  localparam logic [STEP_W-1:0] STEP_LEGAL = STEP_W'(MAX_STEPS - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_step;
  logic              at_last;
  logic              active;

  // Index of the final step for each opcode (instruction length minus one).
  // Undefined opcodes behave as NOP and finish at T1 straight after fetch;
  // every other opcode is at least 3 long, so T0/T1 never look final.
  always_comb begin
    last_step = STEP_1;
    case (ir_op)
      OP_LDA, OP_STA:                                   last_step = STEP_3;
      OP_ADD, OP_SUB:                                   last_step = STEP_4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:     last_step = STEP_2;
      default:                                          last_step = STEP_1;
    endcase
  end

  assign active  = !reset && run && (state_q == ST_RUN);
  assign at_last = (step_q == last_step);

  // State register: step counter plus RUN/HALT state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      step_q  <= STEP_0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic. An out-of-range step is pulled back to 0 on the next
  // edge regardless of run, so a corrupted counter can never stick.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (step_q > STEP_LEGAL) begin
      step_d = STEP_0;
    end else if (state_q == ST_HALT) begin
      step_d = STEP_0;
    end else if (run) begin
      if (ir_op == OP_HLT && step_q == STEP_2) begin
        state_d = ST_HALT;
        step_d  = STEP_0;
      end else if (at_last) begin
        step_d = STEP_0;
      end else begin
        step_d = step_q + STEP_1;
      end
    end
  end

  // Output decode: blank whenever frozen, halted or in reset
  always_comb begin
    ctrl       = 16'h0000;
    instr_done = 1'b0;
    if (active) begin
      instr_done = at_last;
      case (step_q)
        STEP_0: ctrl = C_CO | C_MI;
        STEP_1: ctrl = C_RO | C_II | C_CE;
        STEP_2: begin
          case (ir_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
            OP_LDI:                         ctrl = C_IO | C_AI;
            OP_JMP:                         ctrl = C_IO | C_J;
            OP_JC:                          ctrl = carry_flag ? (C_IO | C_J) : 16'h0000;
            OP_JZ:                          ctrl = zero_flag  ? (C_IO | C_J) : 16'h0000;
            OP_OUT:                         ctrl = C_AO | C_OI;
            OP_HLT:                         ctrl = C_HLT;
            default:                        ctrl = 16'h0000;
          endcase
        end
        STEP_3: begin
          case (ir_op)
            OP_LDA:         ctrl = C_RO | C_AI;
            OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
            OP_STA:         ctrl = C_AO | C_RI;
            default:        ctrl = 16'h0000;
          endcase
        end
        STEP_4: begin
          case (ir_op)
            OP_ADD:  ctrl = C_EO | C_AI | C_FI;
            OP_SUB:  ctrl = C_EO | C_AI | C_FI | C_SU;
            default: ctrl = 16'h0000;
          endcase
        end
        default: ctrl = 16'h0000;
      endcase
    end
  end

  assign step   = step_q;
  assign halted = (state_q == ST_HALT);

  // The NOP opcode is documented only for readability of the decode above
  logic unused_nop;
  assign unused_nop = (OP_NOP == 4'b0000);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed control words.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [3:0]  ir_op;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        instr_done;
  logic        halted;

  int errors;
  int checks;

  control_sequencer #(.STEP_W(3), .MAX_STEPS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .ir_op      (ir_op),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (ctrl),
    .step       (step),
    .instr_done (instr_done),
    .halted     (halted)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all data inputs at once
  task automatic applyStimulus(input logic r, input logic [3:0] op,
                               input logic c, input logic z);
    run        = r;
    ir_op      = op;
    carry_flag = c;
    zero_flag  = z;
    #0;
  endtask

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check ctrl, step and instr_done together
  task automatic checkState(input string tag, input logic [15:0] exp_ctrl,
                            input logic [2:0] exp_step, input logic exp_done);
    checkOutput({tag, ".ctrl"}, ctrl, exp_ctrl);
    checkOutput({tag, ".step"}, {13'd0, step}, {13'd0, exp_step});
    checkOutput({tag, ".done"}, {15'd0, instr_done}, {15'd0, exp_done});
  endtask

  // Expected two back-to-back SUBs
  logic [15:0] sub_ctrl [0:4];
  logic [2:0]  sub_step [0:4];

  initial begin
    errors = 0;
    checks = 0;
    sub_ctrl[0] = 16'h4004; sub_step[0] = 3'd0;
    sub_ctrl[1] = 16'h1408; sub_step[1] = 3'd1;
    sub_ctrl[2] = 16'h4800; sub_step[2] = 3'd2;
    sub_ctrl[3] = 16'h1020; sub_step[3] = 3'd3;
    sub_ctrl[4] = 16'h02C1; sub_step[4] = 3'd4;

    // Reset with LDA presented
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    #1;
    checkOutput("rst.ctrl", ctrl, 16'h0000);
    checkOutput("rst.done", {15'd0, instr_done}, 16'h0000);
    tick();
    reset = 1'b0;
    #0;
    checkOutput("rst.halted", {15'd0, halted}, 16'h0000);

    // LDA
    checkState("lda.t0", 16'h4004, 3'd0, 1'b0);
    tick(); checkState("lda.t1", 16'h1408, 3'd1, 1'b0);
    tick(); checkState("lda.t2", 16'h4800, 3'd2, 1'b0);
    tick(); checkState("lda.t3", 16'h1200, 3'd3, 1'b1);
    tick(); checkOutput("lda.wrap", {13'd0, step}, 16'h0000);

    // Two back-to-back SUBs: 10 cycles total
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkState($sformatf("sub.c%0d", i), sub_ctrl[i % 5], sub_step[i % 5], (i % 5) == 4);
      tick();
    end
    checkOutput("sub.end", {13'd0, step}, 16'h0000);

    // JC not taken
    applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0);
    tick(); tick();
    checkState("jc0.t2", 16'h0000, 3'd2, 1'b1);
    tick(); checkOutput("jc0.wrap", {13'd0, step}, 16'h0000);

    // JC taken
    applyStimulus(1'b1, 4'b0111, 1'b1, 1'b0);
    tick(); tick();
    checkState("jc1.t2", 16'h0802, 3'd2, 1'b1);
    tick(); checkOutput("jc1.wrap", {13'd0, step}, 16'h0000);

    // ADD with run=0 held during T3
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    tick(); tick(); tick();
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkState($sformatf("frz.c%0d", i), 16'h0000, 3'd3, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    checkState("add.t3", 16'h1020, 3'd3, 1'b0);
    tick(); checkState("add.t4", 16'h0281, 3'd4, 1'b1);
    tick(); checkOutput("add.wrap", {13'd0, step}, 16'h0000);

    // Reset at LDA T2, then undefined opcode
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("mid.t2", ctrl, 16'h4800);
    reset = 1'b1;
    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0);
    checkOutput("mid.rst.ctrl", ctrl, 16'h0000);
    tick();
    reset = 1'b0;
    #0;
    checkState("undef.t0", 16'h4004, 3'd0, 1'b0);
    tick(); checkState("undef.t1", 16'h1408, 3'd1, 1'b1);
    tick(); checkOutput("undef.wrap", {13'd0, step}, 16'h0000);

    // HLT and the halted state
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    tick(); tick();
    checkState("hlt.t2", 16'h8000, 3'd2, 1'b1);
    checkOutput("hlt.pre", {15'd0, halted}, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkState($sformatf("halt.c%0d", i), 16'h0000, 3'd0, 1'b0);
      checkOutput($sformatf("halt.h%0d", i), {15'd0, halted}, 16'h0001);
      applyStimulus(1'b1, 4'(i), 1'b1, 1'b1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkState("unhalt.t0", 16'h4004, 3'd0, 1'b0);
    checkOutput("unhalt.halted", {15'd0, halted}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
